// File: rtl/wb_arbiter_if.sv
// Bus bundle for wb_arbiter.
//   slave  : arbiter view (consumes pipeline/long-latency/issue/check inputs,
//            drives lu_ready, busy checks, register-file write port, fifo_count)
//   master : environment view (mirror of slave)
interface wb_arbiter_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          pipe_wb_en;
    logic [4:0]    pipe_wb_addr;
    logic [31:0]   pipe_wb_data;
    logic          lu_valid;
    logic          lu_ready;
    logic [4:0]    lu_addr;
    logic [31:0]   lu_data;
    logic          iss_valid;
    logic [4:0]    iss_addr;
    logic [4:0]    chk_addr1;
    logic [4:0]    chk_addr2;
    logic          chk_busy1;
    logic          chk_busy2;
    logic          RegWrite;
    logic [4:0]    w_reg_addr;
    logic [31:0]   w_data;
    logic [CW-1:0] fifo_count;

    modport slave (
        input  pipe_wb_en, pipe_wb_addr, pipe_wb_data,
        input  lu_valid, lu_addr, lu_data,
        output lu_ready,
        input  iss_valid, iss_addr,
        input  chk_addr1, chk_addr2,
        output chk_busy1, chk_busy2,
        output RegWrite, w_reg_addr, w_data,
        output fifo_count
    );

    modport master (
        output pipe_wb_en, pipe_wb_addr, pipe_wb_data,
        output lu_valid, lu_addr, lu_data,
        input  lu_ready,
        output iss_valid, iss_addr,
        output chk_addr1, chk_addr2,
        input  chk_busy1, chk_busy2,
        input  RegWrite, w_reg_addr, w_data,
        input  fifo_count
    );
endinterface

// File: rtl/wb_arbiter.sv
// Write-back arbiter owning the integer register file's single write port.
// Pipeline write-back has fixed priority; long-latency results are accepted
// on a valid/ready handshake into a DEPTH-entry FIFO and drained whenever the
// pipeline is not writing. A 32-bit busy scoreboard tracks destinations of
// issued long-latency ops until their result is written.
// Ports:
//   clk   : clock
//   reset : asynchronous active-high reset
//   bus   : wb_arbiter_if.slave (pipeline wb, lu handshake, issue, busy
//           checks, register-file write port, fifo_count)
module wb_arbiter #(
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    wb_arbiter_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [4:0]    addr_mem_q [DEPTH];
    logic [31:0]   data_mem_q [DEPTH];
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   busy_q, busy_d;

    logic          lu_ready;
    logic          fifo_empty;
    logic          pipe_sel;
    logic          push;
    logic          pop;
    logic [4:0]    head_addr;
    logic [31:0]   head_data;

    assign lu_ready   = (count_q < CW'(DEPTH));
    assign fifo_empty = (count_q == '0);
    assign pipe_sel   = bus.pipe_wb_en && (bus.pipe_wb_addr != 5'd0);
    // Address-0 results are handshaken but dropped, never stored.
    assign push       = bus.lu_valid && lu_ready && (bus.lu_addr != 5'd0);
    assign pop        = !fifo_empty && !pipe_sel;
    assign head_addr  = addr_mem_q[head_q];
    assign head_data  = data_mem_q[head_q];

    // Storage needs no reset: it is only read while count_q says it is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem_q[tail_q] <= bus.lu_addr;
            data_mem_q[tail_q] <= bus.lu_data;
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) begin
            tail_d = tail_q + AW'(1);
        end
        if (pop) begin
            head_d = head_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Clear first, then set, so an issue to the popping register keeps it busy.
    always_comb begin
        busy_d = busy_q;
        if (pop) begin
            busy_d[head_addr] = 1'b0;
        end
        if (bus.iss_valid && (bus.iss_addr != 5'd0)) begin
            busy_d[bus.iss_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            busy_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        bus.RegWrite   = 1'b0;
        bus.w_reg_addr = '0;
        bus.w_data     = '0;
        if (pipe_sel) begin
            bus.RegWrite   = 1'b1;
            bus.w_reg_addr = bus.pipe_wb_addr;
            bus.w_data     = bus.pipe_wb_data;
        end else if (!fifo_empty) begin
            bus.RegWrite   = 1'b1;
            bus.w_reg_addr = head_addr;
            bus.w_data     = head_data;
        end
    end

    assign bus.lu_ready   = lu_ready;
    assign bus.fifo_count = count_q;
    assign bus.chk_busy1  = busy_q[bus.chk_addr1];
    assign bus.chk_busy2  = busy_q[bus.chk_addr2];

endmodule
